// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: MIPS fetch with PC, req/ack instruction memory, IF/ID register, skid buffer and redirect flush
module instr_fetch_stage #(
  parameter int PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  input  logic                stall,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                id_valid,
  output logic [PC_WIDTH-1:0] id_pc,
  output logic [PC_WIDTH-1:0] id_pc_plus4,
  output logic [31:0]         id_instr,
  output logic [5:0]          OP,
  output logic [5:0]          funct,
  output logic [4:0]          rs,
  output logic [4:0]          rt,
  output logic [4:0]          rd,
  output logic [15:0]         imm
);
  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;
  state_t state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d, addr_q, addr_d, id_pc_q, id_pc_d, skid_pc_q, skid_pc_d, pc_inc;
  logic req_q, req_d, id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d, skid_instr_q, skid_instr_d;
  logic ack;
  assign ack = imem_ack & req_q;
  assign pc_inc = pc_q + PC_WIDTH'(4);
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    id_valid_d = id_valid_q;
    id_instr_d = id_instr_q;
    id_pc_d = id_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d = skid_pc_q;
    if (redirect) begin
      id_valid_d = 1'b0;
      id_instr_d = '0;
      skid_instr_d = '0;
      skid_pc_d = '0;
      pc_d = {redirect_pc[PC_WIDTH-1:2], 2'b00};
      // an unanswered request must still be retired before refetching
      state_d = (state_q == DISCARD || (state_q == FETCH && !ack)) ? DISCARD : FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (ack && (!id_valid_q || !stall)) begin
            id_valid_d = 1'b1;
            id_instr_d = imem_rdata;
            id_pc_d = pc_q;
            pc_d = pc_inc;
          end else if (ack) begin
            skid_instr_d = imem_rdata;
            skid_pc_d = pc_q;
            pc_d = pc_inc;
            state_d = HOLD;
          end else if (!stall) begin
            id_valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            id_valid_d = 1'b1;
            id_instr_d = skid_instr_q;
            id_pc_d = skid_pc_q;
            skid_instr_d = '0;
            skid_pc_d = '0;
            state_d = FETCH;
          end
        end
        default: state_d = ack ? FETCH : DISCARD;
      endcase
    end
    addr_d = (state_d == DISCARD) ? addr_q : pc_d;
    req_d = state_d != HOLD;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q <= RESET_PC;
      addr_q <= RESET_PC;
      req_q <= 1'b0;
      id_valid_q <= 1'b0;
      id_instr_q <= '0;
      id_pc_q <= '0;
      skid_instr_q <= '0;
      skid_pc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      addr_q <= addr_d;
      req_q <= req_d;
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc_q <= id_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q <= skid_pc_d;
    end
  end
  assign imem_req = req_q;
  assign imem_addr = addr_q;
  assign id_valid = id_valid_q;
  assign id_instr = id_instr_q;
  assign id_pc = id_pc_q;
  assign id_pc_plus4 = id_pc_q + PC_WIDTH'(4);
  assign OP = id_instr_q[31:26];
  assign funct = id_instr_q[5:0];
  assign rs = id_instr_q[25:21];
  assign rt = id_instr_q[20:16];
  assign rd = id_instr_q[15:11];
  assign imm = id_instr_q[15:0];
endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb_instr_fetch_stage: directed bench with a scoreboard of expected IF/ID entries
module tb_instr_fetch_stage;
  logic clk = 0, rst = 1;
  logic imem_req, imem_ack = 0, stall = 0, redirect = 0, id_valid;
  logic [31:0] imem_addr, imem_rdata = 0, redirect_pc = 0, id_pc, id_pc_plus4, id_instr;
  logic [5:0] OP, funct;
  logic [4:0] rs, rt, rd;
  logic [15:0] imm;
  logic w_req, w_ack = 0, w_valid;
  logic [31:0] w_addr, w_rdata = 0, w_pc, w_pc4, w_instr;
  logic [5:0] w_op, w_funct;
  logic [4:0] w_rs, w_rt, w_rd;
  logic [15:0] w_imm;
  int checks = 0, errors = 0;
  typedef struct {logic [31:0] instr; logic [31:0] pc;} ent_t;
  ent_t sb[$];

  always #5 clk = ~clk;

  instr_fetch_stage dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .id_instr(id_instr),
    .OP(OP), .funct(funct), .rs(rs), .rt(rt), .rd(rd), .imm(imm));

  instr_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack),
    .imem_rdata(w_rdata), .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
    .id_valid(w_valid), .id_pc(w_pc), .id_pc_plus4(w_pc4), .id_instr(w_instr),
    .OP(w_op), .funct(w_funct), .rs(w_rs), .rt(w_rt), .rd(w_rd), .imm(w_imm));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] w, input logic [31:0] a);
    ent_t e;
    e.instr = w;
    e.pc = a;
    sb.push_back(e);
  endtask

  task automatic pop_chk();
    ent_t e;
    logic [31:0] w;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard: observed empty expected entry");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      w = e.instr;
      chk("id_valid", {31'b0, id_valid}, 32'd1);
      chk("id_instr", id_instr, w);
      chk("id_pc", id_pc, e.pc);
      chk("id_pc_plus4", id_pc_plus4, e.pc + 32'd4);
      chk("OP", {26'b0, OP}, {26'b0, w[31:26]});
      chk("funct", {26'b0, funct}, {26'b0, w[5:0]});
    end
  endtask

  initial begin
    #12;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_instr", id_instr, 32'd0);
    chk("rst_pc", id_pc, 32'd0);
    rst = 0;
    tick();
    chk("req_after_rst", {31'b0, imem_req}, 32'd1);
    chk("addr0", imem_addr, 32'h0);
    imem_ack = 1; imem_rdata = 32'h8C22_0004; push(imem_rdata, 32'h0);
    tick();
    chk("addr4", imem_addr, 32'h4);
    pop_chk();
    imem_rdata = 32'h0800_0010; push(imem_rdata, 32'h4);
    tick();
    chk("addr8", imem_addr, 32'h8);
    pop_chk();
    imem_rdata = 32'h0085_1020; push(imem_rdata, 32'h8);
    tick();
    pop_chk();
    chk("add_OP", {26'b0, OP}, 32'h0);
    chk("add_rs", {27'b0, rs}, 32'd4);
    chk("add_rt", {27'b0, rt}, 32'd5);
    chk("add_rd", {27'b0, rd}, 32'd2);
    chk("add_funct", {26'b0, funct}, 32'h20);
    chk("add_imm", {16'b0, imm}, 32'h1020);
    chk("add_plus4", id_pc_plus4, 32'hC);
    stall = 1; imem_rdata = 32'h2108_0001;
    tick();
    chk("hold_req", {31'b0, imem_req}, 32'd0);
    chk("hold_instr", id_instr, 32'h0085_1020);
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("hold2_instr", id_instr, 32'h0085_1020);
    chk("hold2_valid", {31'b0, id_valid}, 32'd1);
    chk("hold2_rd", {27'b0, rd}, 32'd2);
    imem_ack = 0; stall = 0; push(32'h2108_0001, 32'hC);
    tick();
    pop_chk();
    chk("resume_req", {31'b0, imem_req}, 32'd1);
    chk("resume_addr", imem_addr, 32'h10);
    tick();
    chk("consumed_valid", {31'b0, id_valid}, 32'd0);
    redirect = 1; redirect_pc = 32'h103;
    tick();
    chk("disc_valid", {31'b0, id_valid}, 32'd0);
    chk("disc_instr", id_instr, 32'h0);
    chk("disc_addr", imem_addr, 32'h10);
    redirect = 0;
    tick();
    tick();
    imem_ack = 1; imem_rdata = 32'hBAD0_BAD0;
    tick();
    chk("disc_drop_valid", {31'b0, id_valid}, 32'd0);
    chk("redir_addr", imem_addr, 32'h100);
    imem_rdata = 32'h1000_FFFF; push(imem_rdata, 32'h100);
    tick();
    pop_chk();
    stall = 1; redirect = 1; redirect_pc = 32'h200; imem_rdata = 32'hBAD1_BAD1;
    tick();
    chk("redir_ack_addr", imem_addr, 32'h200);
    chk("redir_ack_valid", {31'b0, id_valid}, 32'd0);
    chk("redir_ack_instr", id_instr, 32'h0);
    redirect = 0; imem_rdata = 32'h0000_0008; push(imem_rdata, 32'h200);
    tick();
    pop_chk();
    imem_ack = 0;
    tick();
    chk("stall_keep_valid", {31'b0, id_valid}, 32'd1);
    chk("stall_keep_instr", id_instr, 32'h0000_0008);
    stall = 0;
    chk("wrap_addr0", w_addr, 32'hFFFF_FFF8);
    w_ack = 1; w_rdata = 32'h1111_1111;
    tick();
    chk("wrap_addr1", w_addr, 32'hFFFF_FFFC);
    chk("wrap_pc0", w_pc, 32'hFFFF_FFF8);
    w_rdata = 32'h2222_2222;
    tick();
    chk("wrap_addr2", w_addr, 32'h0);
    chk("wrap_pc1", w_pc, 32'hFFFF_FFFC);
    chk("wrap_plus4", w_pc4, 32'h0);
    w_ack = 0;
    #2 rst = 1;
    #1;
    chk("arst_req", {31'b0, imem_req}, 32'd0);
    chk("arst_valid", {31'b0, id_valid}, 32'd0);
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_waddr", w_addr, 32'hFFFF_FFF8);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
